// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory over
// a req/ack handshake and holds one instruction for the IF/ID register.
// Handles branch redirect (keeping the delay slot) and exception flush.
// Optional build macro: IF_PC_ALIGN_CHK_EN -- when defined, a misaligned PC
// produces a faulting buffer entry (if_adel=1) instead of a memory request.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel,
  output logic        stallreq_if
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FULL
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;
  logic        buf_adel;
  logic        pending;
  logic [31:0] redirect_target;

  logic        branch_take;
  logic        misaligned;
  logic        fault_hold;

  // Only the IF/ID and ID hold bits matter to this stage.
  logic        unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  assign branch_take = branch_flag && !stall[2];
  assign fault_hold  = buf_adel;

`ifdef IF_PC_ALIGN_CHK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Request generation: combinational so a 0-wait ack can land in the same cycle.
  always_comb begin
    inst_req = 1'b0;
    if (!rst && !flush) begin
      case (state)
        FETCH:   inst_req = !misaligned;
        FULL:    inst_req = !fault_hold && !stall[1] && !branch_take;
        default: inst_req = 1'b0;
      endcase
    end
  end

  // Address is word-aligned and only driven while a request is out.
  always_comb begin
    inst_addr = '0;
    if (inst_req) inst_addr = {pc[31:2], 2'b00};
  end

  // Buffer presentation to IF/ID; empty buffer reads as a NOP.
  always_comb begin
    if_pc       = '0;
    if_inst     = '0;
    stallreq_if = 1'b1;
    if (state == FULL) begin
      if_pc       = buf_pc;
      if_inst     = buf_inst;
      stallreq_if = 1'b0;
    end
  end

`ifdef IF_PC_ALIGN_CHK_EN
  assign if_adel = (state == FULL) && buf_adel;
`else
  assign if_adel = 1'b0;
`endif

  // Fetch FSM, PC, single-entry buffer and pending-redirect bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      buf_pc          <= '0;
      buf_inst        <= '0;
      buf_adel        <= 1'b0;
      pending         <= 1'b0;
      redirect_target <= '0;
    end else if (flush) begin
      state    <= FETCH;
      pc       <= new_pc;
      buf_adel <= 1'b0;
      pending  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;

        FETCH: begin
          if (misaligned) begin
            // Faulting entry is parked in the buffer; pc stays put.
            buf_pc   <= pc;
            buf_inst <= '0;
            buf_adel <= 1'b1;
            state    <= FULL;
          end else if (inst_ack) begin
            buf_pc   <= pc;
            buf_inst <= inst_rdata;
            buf_adel <= 1'b0;
            pending  <= 1'b0;
            state    <= FULL;
            // A branch seen here means the returning word is its delay slot.
            if (branch_take)  pc <= branch_target;
            else if (pending) pc <= redirect_target;
            else              pc <= pc + STEP;
          end else if (branch_take) begin
            pending         <= 1'b1;
            redirect_target <= branch_target;
          end
        end

        FULL: begin
          if (!fault_hold) begin
            if (branch_take) begin
              // Buffer already holds the delay slot; it drains normally.
              pc <= branch_target;
              if (!stall[1]) state <= FETCH;
            end else if (!stall[1]) begin
              if (inst_ack) begin
                buf_pc   <= pc;
                buf_inst <= inst_rdata;
                pc       <= pc + STEP;
              end else begin
                state <= FETCH;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for the instruction-fetch stage.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic        stallreq_if;

  int checks = 0;
  int errors = 0;

  if_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rdata(inst_rdata), .if_pc(if_pc), .if_inst(if_inst),
    .if_adel(if_adel), .stallreq_if(stallreq_if)
  );

  always #5 clk = ~clk;

  // Memory contents: every word is a recognisable function of its address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A00_0001;
  endfunction

  // Advance to the next falling edge and return inputs to idle defaults.
  task automatic cyc();
    @(negedge clk);
    stall       = '0;
    flush       = 1'b0;
    branch_flag = 1'b0;
    inst_ack    = 1'b0;
    inst_rdata  = 32'hDEAD_BEEF;
  endtask

  // Flush to a known address; leaves the stage in FETCH at that pc.
  task automatic go_to(input logic [31:0] a);
    cyc();
    flush = 1'b1; new_pc = a; inst_ack = 1'b1;
    #1;
    checks++;
    if ({inst_req, inst_addr} !== {1'b0, 32'h0}) begin
      $display("FAIL goto_req got req=%b addr=%h exp req=0 addr=0", inst_req, inst_addr); errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc(); #1;
    checks++;
    if ({inst_req, inst_addr, if_pc, if_inst, if_adel, stallreq_if} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
      $display("FAIL reset_out got req=%b addr=%h pc=%h inst=%h adel=%b sreq=%b exp 0,0,0,0,0,1",
               inst_req, inst_addr, if_pc, if_inst, if_adel, stallreq_if); errors++;
    end
  endtask

  task automatic test_sequential();
    cyc(); rst = 1'b0; #1;
    checks++;
    if (inst_req !== 1'b0) begin
      $display("FAIL seq_idle got req=%b exp 0", inst_req); errors++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      inst_ack = 1'b1; inst_rdata = mem(32'(4 * i));
      #1;
      checks++;
      if ({inst_req, inst_addr} !== {1'b1, 32'(4 * i)}) begin
        $display("FAIL seq_addr%0d got req=%b addr=%h exp req=1 addr=%h", i, inst_req, inst_addr, 32'(4 * i)); errors++;
      end
      checks++;
      if (i == 0) begin
        if ({stallreq_if, if_inst} !== {1'b1, 32'h0}) begin
          $display("FAIL seq_first got sreq=%b inst=%h exp sreq=1 inst=0", stallreq_if, if_inst); errors++;
        end
      end else if ({stallreq_if, if_pc, if_inst} !== {1'b0, 32'(4 * (i - 1)), mem(32'(4 * (i - 1)))}) begin
        $display("FAIL seq_buf%0d got sreq=%b pc=%h inst=%h exp sreq=0 pc=%h", i, stallreq_if, if_pc, if_inst, 32'(4 * (i - 1))); errors++;
      end
    end
    cyc(); #1;
    checks++;
    if ({if_pc, if_inst, inst_req, inst_addr} !== {32'hC, mem(32'hC), 1'b1, 32'h10}) begin
      $display("FAIL seq_last got pc=%h inst=%h req=%b addr=%h exp pc=c req=1 addr=10", if_pc, if_inst, inst_req, inst_addr); errors++;
    end
  endtask

  task automatic test_wait_ack();
    go_to(32'h10);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      checks++;
      if ({inst_req, inst_addr, stallreq_if, if_inst} !== {1'b1, 32'h10, 1'b1, 32'h0}) begin
        $display("FAIL wait_hold%0d got req=%b addr=%h sreq=%b inst=%h exp 1,10,1,0", i, inst_req, inst_addr, stallreq_if, if_inst); errors++;
      end
    end
    cyc(); inst_ack = 1'b1; inst_rdata = mem(32'h10); #1;
    checks++;
    if ({inst_addr, if_inst} !== {32'h10, 32'h0}) begin
      $display("FAIL wait_ackcyc got addr=%h inst=%h exp 10,0", inst_addr, if_inst); errors++;
    end
    cyc(); #1;
    checks++;
    if ({stallreq_if, if_pc, if_inst, inst_addr} !== {1'b0, 32'h10, mem(32'h10), 32'h14}) begin
      $display("FAIL wait_done got sreq=%b pc=%h inst=%h addr=%h exp 0,10,-,14", stallreq_if, if_pc, if_inst, inst_addr); errors++;
    end
  endtask

  task automatic test_stall();
    go_to(32'h20);
    cyc(); inst_ack = 1'b1; inst_rdata = mem(32'h20);
    for (int i = 0; i < 2; i++) begin
      cyc(); stall = 6'b000011; inst_ack = (i == 1); inst_rdata = 32'hBAD0_0000; #1;
      checks++;
      if ({inst_req, inst_addr, if_pc, if_inst} !== {1'b0, 32'h0, 32'h20, mem(32'h20)}) begin
        $display("FAIL stall_hold%0d got req=%b addr=%h pc=%h inst=%h exp 0,0,20,-", i, inst_req, inst_addr, if_pc, if_inst); errors++;
      end
    end
    cyc(); inst_ack = 1'b1; inst_rdata = mem(32'h24); #1;
    checks++;
    if ({inst_req, inst_addr, if_pc} !== {1'b1, 32'h24, 32'h20}) begin
      $display("FAIL stall_release got req=%b addr=%h pc=%h exp 1,24,20", inst_req, inst_addr, if_pc); errors++;
    end
    cyc(); #1;
    checks++;
    if ({if_pc, if_inst} !== {32'h24, mem(32'h24)}) begin
      $display("FAIL stall_refill got pc=%h inst=%h exp pc=24", if_pc, if_inst); errors++;
    end
  endtask

  task automatic test_branch_pending();
    go_to(32'h40);
    cyc(); inst_ack = 1'b1; inst_rdata = mem(32'h40);
    cyc(); #1;
    checks++;
    if ({if_pc, inst_addr} !== {32'h40, 32'h44}) begin
      $display("FAIL br_pre got pc=%h addr=%h exp 40,44", if_pc, inst_addr); errors++;
    end
    cyc(); branch_flag = 1'b1; branch_target = 32'h100; #1;
    checks++;
    if ({inst_req, inst_addr, stallreq_if} !== {1'b1, 32'h44, 1'b1}) begin
      $display("FAIL br_issue got req=%b addr=%h sreq=%b exp 1,44,1", inst_req, inst_addr, stallreq_if); errors++;
    end
    cyc(); #1;
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h44}) begin
      $display("FAIL br_wait got req=%b addr=%h exp 1,44", inst_req, inst_addr); errors++;
    end
    cyc(); inst_ack = 1'b1; inst_rdata = mem(32'h44); #1;
    checks++;
    if (inst_addr !== 32'h44) begin
      $display("FAIL br_slot_addr got %h exp 44", inst_addr); errors++;
    end
    cyc(); inst_ack = 1'b1; inst_rdata = mem(32'h100); #1;
    checks++;
    if ({if_pc, if_inst, inst_req, inst_addr} !== {32'h44, mem(32'h44), 1'b1, 32'h100}) begin
      $display("FAIL br_redirect got pc=%h inst=%h req=%b addr=%h exp 44,-,1,100", if_pc, if_inst, inst_req, inst_addr); errors++;
    end
    cyc(); #1;
    checks++;
    if ({if_pc, if_inst, inst_addr} !== {32'h100, mem(32'h100), 32'h104}) begin
      $display("FAIL br_target got pc=%h inst=%h addr=%h exp 100,-,104", if_pc, if_inst, inst_addr); errors++;
    end
  endtask

  task automatic test_branch_full();
    go_to(32'h60);
    cyc(); inst_ack = 1'b1; inst_rdata = mem(32'h60);
    cyc(); branch_flag = 1'b1; branch_target = 32'h200; inst_ack = 1'b1; inst_rdata = mem(32'h64); #1;
    checks++;
    if ({inst_req, inst_addr, if_pc} !== {1'b0, 32'h0, 32'h60}) begin
      $display("FAIL brf_suppress got req=%b addr=%h pc=%h exp 0,0,60", inst_req, inst_addr, if_pc); errors++;
    end
    cyc(); inst_ack = 1'b1; inst_rdata = mem(32'h200); #1;
    checks++;
    if ({inst_req, inst_addr, stallreq_if} !== {1'b1, 32'h200, 1'b1}) begin
      $display("FAIL brf_target got req=%b addr=%h sreq=%b exp 1,200,1", inst_req, inst_addr, stallreq_if); errors++;
    end
    cyc(); #1;
    checks++;
    if ({if_pc, if_inst} !== {32'h200, mem(32'h200)}) begin
      $display("FAIL brf_buf got pc=%h inst=%h exp 200", if_pc, if_inst); errors++;
    end
  endtask

  task automatic test_branch_ack_same();
    go_to(32'h80);
    cyc(); branch_flag = 1'b1; branch_target = 32'h300; inst_ack = 1'b1; inst_rdata = mem(32'h80);
    cyc(); #1;
    checks++;
    if ({if_pc, if_inst, inst_addr} !== {32'h80, mem(32'h80), 32'h300}) begin
      $display("FAIL brs_slot got pc=%h inst=%h addr=%h exp 80,-,300", if_pc, if_inst, inst_addr); errors++;
    end
  endtask

  task automatic test_flush();
    go_to(32'h200);
    cyc(); #1;
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h200}) begin
      $display("FAIL fl_pre got req=%b addr=%h exp 1,200", inst_req, inst_addr); errors++;
    end
    cyc(); flush = 1'b1; new_pc = 32'h180; inst_ack = 1'b1; inst_rdata = mem(32'h200); #1;
    checks++;
    if ({inst_req, inst_addr} !== {1'b0, 32'h0}) begin
      $display("FAIL fl_drop got req=%b addr=%h exp 0,0", inst_req, inst_addr); errors++;
    end
    cyc(); #1;
    checks++;
    if ({stallreq_if, if_pc, if_inst, inst_req, inst_addr} !== {1'b1, 32'h0, 32'h0, 1'b1, 32'h180}) begin
      $display("FAIL fl_after got sreq=%b pc=%h inst=%h req=%b addr=%h exp 1,0,0,1,180", stallreq_if, if_pc, if_inst, inst_req, inst_addr); errors++;
    end
    // Pending redirect must be discarded by a flush.
    go_to(32'h1C0);
    cyc(); branch_flag = 1'b1; branch_target = 32'h3C0;
    go_to(32'h240);
    cyc(); inst_ack = 1'b1; inst_rdata = mem(32'h240);
    cyc(); #1;
    checks++;
    if ({if_pc, inst_addr} !== {32'h240, 32'h244}) begin
      $display("FAIL fl_pending got pc=%h addr=%h exp 240,244", if_pc, inst_addr); errors++;
    end
  endtask

  task automatic test_wrap();
    go_to(32'hFFFF_FFFC);
    cyc(); inst_ack = 1'b1; inst_rdata = mem(32'hFFFF_FFFC);
    cyc(); #1;
    checks++;
    if ({if_pc, inst_req, inst_addr} !== {32'hFFFF_FFFC, 1'b1, 32'h0}) begin
      $display("FAIL wrap got pc=%h req=%b addr=%h exp fffffffc,1,0", if_pc, inst_req, inst_addr); errors++;
    end
  endtask

  task automatic test_align();
`ifdef IF_PC_ALIGN_CHK_EN
    go_to(32'h102);
    cyc(); inst_ack = 1'b1; #1;
    checks++;
    if ({inst_req, inst_addr, stallreq_if} !== {1'b0, 32'h0, 1'b1}) begin
      $display("FAIL adel_noreq got req=%b addr=%h sreq=%b exp 0,0,1", inst_req, inst_addr, stallreq_if); errors++;
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); inst_ack = 1'b1; #1;
      checks++;
      if ({if_pc, if_inst, if_adel, inst_req, stallreq_if} !== {32'h102, 32'h0, 1'b1, 1'b0, 1'b0}) begin
        $display("FAIL adel_hold%0d got pc=%h inst=%h adel=%b req=%b sreq=%b exp 102,0,1,0,0", i, if_pc, if_inst, if_adel, inst_req, stallreq_if); errors++;
      end
    end
    go_to(32'h400);
    cyc(); #1;
    checks++;
    if ({if_adel, inst_req, inst_addr} !== {1'b0, 1'b1, 32'h400}) begin
      $display("FAIL adel_clear got adel=%b req=%b addr=%h exp 0,1,400", if_adel, inst_req, inst_addr); errors++;
    end
`else
    go_to(32'h102);
    cyc(); inst_ack = 1'b1; inst_rdata = mem(32'h100); #1;
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h100}) begin
      $display("FAIL unal_addr got req=%b addr=%h exp 1,100", inst_req, inst_addr); errors++;
    end
    cyc(); #1;
    checks++;
    if ({if_pc, if_inst, if_adel, inst_addr} !== {32'h102, mem(32'h100), 1'b0, 32'h104}) begin
      $display("FAIL unal_buf got pc=%h inst=%h adel=%b addr=%h exp 102,-,0,104", if_pc, if_inst, if_adel, inst_addr); errors++;
    end
`endif
  endtask

  task automatic test_reset_mid_request();
    go_to(32'h500);
    cyc(); rst = 1'b1; inst_ack = 1'b1; inst_rdata = mem(32'h500); #1;
    checks++;
    if (inst_req !== 1'b0) begin
      $display("FAIL rst_mid_req got req=%b exp 0", inst_req); errors++;
    end
    cyc(); rst = 1'b0; #1;
    checks++;
    if ({inst_req, stallreq_if, if_pc, if_inst} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
      $display("FAIL rst_mid_state got req=%b sreq=%b pc=%h inst=%h exp 0,1,0,0", inst_req, stallreq_if, if_pc, if_inst); errors++;
    end
    cyc(); #1;
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL rst_mid_refetch got req=%b addr=%h exp 1,0", inst_req, inst_addr); errors++;
    end
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
    branch_flag = 1'b0; branch_target = '0; inst_ack = 1'b0; inst_rdata = '0;
    test_reset();
    test_sequential();
    test_wait_ack();
    test_stall();
    test_branch_pending();
    test_branch_full();
    test_branch_ack_same();
    test_flush();
    test_wrap();
    test_align();
    test_reset_mid_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
